// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the iterative multiply/divide unit.
//   muldiv_op_t    - operation encoding on the op port
//   muldiv_state_t - control FSM states
//   op_is_signed / op_is_div - small decode helpers
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FIX   = 2'b10,
    ZDONE = 2'b11
  } muldiv_state_t;

  function automatic logic op_is_signed(input muldiv_op_t o);
    return (o == MULT) || (o == DIV);
  endfunction

  function automatic logic op_is_div(input muldiv_op_t o);
    return (o == DIV) || (o == DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// cond_negate: combinational conditional two's-complement negation.
//   in_i  [W-1:0] value
//   neg_i         1 = negate, 0 = pass through
//   out_o [W-1:0] neg_i ? -in_i : in_i
module cond_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_i,
  output logic [W-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + W'(1)) : in_i;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply and divide producing HI/LO.
//   clock    system clock, rising edge
//   reset    synchronous, active-low
//   start    operation request, sampled only in IDLE
//   op       MULT / MULTU / DIV / DIVU (muldiv_op_t encoding)
//   a, b     operands, sampled on the accept edge
//   busy     high from accept until the edge that raises done
//   done     one-cycle completion pulse
//   div_zero valid with done; set when a divide had b == 0
//   hi, lo   multiply: product upper/lower; divide: remainder/quotient
// Operands are reduced to magnitudes on accept, the unsigned core runs
// WIDTH iterations, and the sign is restored in the FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  muldiv_state_t    state_q;
  muldiv_op_t       op_q;
  logic [CNT_W-1:0] cnt_q;
  // Multiplicand for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]   mcand_q;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide: lower half holds dividend bits shifting out / quotient bits in.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   rem_q;
  logic               neg_lo_q;
  logic               neg_hi_q;
  logic               busy_q;
  logic               done_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Operand decode and magnitudes at accept time.
  muldiv_op_t       op_in;
  logic             signed_in;
  logic             neg_a_in;
  logic             neg_b_in;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign op_in     = muldiv_op_t'(op);
  assign signed_in = op_is_signed(op_in);
  assign neg_a_in  = signed_in & a[WIDTH-1];
  assign neg_b_in  = signed_in & b[WIDTH-1];

  // MIN negates to itself, which read as unsigned is exactly 2^(WIDTH-1).
  cond_negate #(.W(WIDTH)) u_abs_a (.in_i(a), .neg_i(neg_a_in), .out_o(mag_a));
  cond_negate #(.W(WIDTH)) u_abs_b (.in_i(b), .neg_i(neg_b_in), .out_o(mag_b));

  // Multiply step: conditionally add multiplicand into upper half, then
  // shift the whole accumulator right, carry included.
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_acc_d;

  assign add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign mul_acc_d = {add_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step on a WIDTH+1 bit partial remainder. The stored
  // remainder is always below the divisor, so WIDTH bits hold it between
  // steps; the extra bit only exists during the trial subtract.
  logic [WIDTH:0]     part_rem;
  logic [WIDTH:0]     diff;
  logic               fits;
  logic [WIDTH-1:0]   div_rem_d;
  logic [2*WIDTH-1:0] div_acc_d;

  assign part_rem  = {rem_q, acc_q[WIDTH-1]};
  assign diff      = part_rem - {1'b0, mcand_q};
  assign fits      = ~diff[WIDTH];
  assign div_rem_d = fits ? diff[WIDTH-1:0] : part_rem[WIDTH-1:0];
  assign div_acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], fits};

  // Sign correction of the finished magnitudes.
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  cond_negate #(.W(2*WIDTH)) u_fix_prod (
    .in_i(acc_q), .neg_i(neg_lo_q), .out_o(prod_fixed)
  );
  cond_negate #(.W(WIDTH)) u_fix_quot (
    .in_i(acc_q[WIDTH-1:0]), .neg_i(neg_lo_q), .out_o(quot_fixed)
  );
  cond_negate #(.W(WIDTH)) u_fix_rem (
    .in_i(rem_q), .neg_i(neg_hi_q), .out_o(rem_fixed)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= MULT;
      cnt_q      <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q   <= op_in;
            cnt_q  <= CNT_W'(WIDTH);
            rem_q  <= '0;
            busy_q <= 1'b1;
            if (op_is_div(op_in)) begin
              mcand_q  <= mag_b;
              acc_q    <= {{WIDTH{1'b0}}, mag_a};
              neg_lo_q <= neg_a_in ^ neg_b_in;
              // Truncating division: remainder follows the dividend.
              neg_hi_q <= neg_a_in;
              state_q  <= (b == '0) ? ZDONE : RUN;
            end else begin
              mcand_q  <= mag_a;
              acc_q    <= {{WIDTH{1'b0}}, mag_b};
              neg_lo_q <= neg_a_in ^ neg_b_in;
              neg_hi_q <= neg_a_in ^ neg_b_in;
              state_q  <= RUN;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (op_is_div(op_q)) begin
            acc_q <= div_acc_d;
            rem_q <= div_rem_d;
          end else begin
            acc_q <= mul_acc_d;
          end
          if (cnt_q == CNT_W'(1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (op_is_div(op_q)) begin
            hi_q <= rem_fixed;
            lo_q <= quot_fixed;
          end else begin
            hi_q <= prod_fixed[2*WIDTH-1:WIDTH];
            lo_q <= prod_fixed[WIDTH-1:0];
          end
          div_zero_q <= 1'b0;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        ZDONE: begin
          // hi/lo deliberately keep the previous result.
          div_zero_q <= 1'b1;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
